sram_axi_bridge: RTL and testbench

Converts the core's two SRAM-like request/response ports (instruction and data) into a single AXI3 master port, 32-bit data, single-beat transfers only. Sits directly below `mycpu_core` in the top-level wrapper: the core's `inst_sram_*` and `data_sram_*` ports connect here, and the AXI port goes to the SoC interconnect. It holds at most one read and one write in flight and returns `data_ok` to each requester in request order.

---
 rtl/sram_axi_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// SRAM-like inst/data ports to one AXI3 master, single-beat, 32-bit.
// Ports: clk, resetn, inst_sram_*, data_sram_*, AXI AR/R/AW/W/B channels.
module sram_axi_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_R    = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_AW_W = 2'd1;
  localparam logic [1:0] W_B    = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state;
  logic        r_id;
  logic        rsp_id;
  logic [31:0] ar_addr_q;
  logic [1:0]  ar_size_q;
  logic [31:0] rdata_q;
  logic [31:0] aw_addr_q;
  logic [1:0]  aw_size_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done;
  logic        w_done;

  logic r_idle;
  logic w_idle;
  logic data_rd_busy;
  logic data_rd_acc;
  logic inst_rd_acc;
  logic data_wr_acc;
  logic aw_fin;
  logic w_fin;

  assign r_idle = (r_state == R_IDLE);
  assign w_idle = (w_state == W_IDLE);
  assign data_rd_busy = !r_idle && r_id;

  // Reads wait for an idle write side so a load never overtakes a store.
  assign data_rd_acc = resetn && data_sram_req && !data_sram_wr &&
                       r_idle && w_idle;
  assign inst_rd_acc = resetn && inst_sram_req && r_idle && w_idle &&
                       !data_rd_acc;
  assign data_wr_acc = resetn && data_sram_req && data_sram_wr &&
                       w_idle && !data_rd_busy;

  assign inst_sram_addr_ok = inst_rd_acc;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;

  assign inst_sram_data_ok = (r_state == R_RESP) && !rsp_id;
  assign data_sram_data_ok = ((r_state == R_RESP) && rsp_id) ||
                             (w_state == W_RESP);

  assign inst_sram_rdata = rdata_q;
  assign data_sram_rdata = rdata_q;

  assign arid    = {3'b000, r_id};
  assign araddr  = ar_addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, ar_size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (r_state == R_AR);
  assign rready  = (r_state == R_R);

  assign awid    = 4'd1;
  assign awaddr  = aw_addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, aw_size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (w_state == W_AW_W) && !aw_done;
  assign wid     = 4'd1;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (w_state == W_AW_W) && !w_done;
  assign bready  = (w_state == W_B);

  // AW and W complete independently; remember whichever finished first.
  assign aw_fin = aw_done || (awvalid && awready);
  assign w_fin  = w_done || (wvalid && wready);

  logic unused_ok;
  assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                       rid[3:1], rresp, rlast, bid, bresp};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= R_IDLE;
      r_id      <= 1'b0;
      rsp_id    <= 1'b0;
      ar_addr_q <= 32'd0;
      ar_size_q <= 2'd0;
      rdata_q   <= 32'd0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (data_rd_acc || inst_rd_acc) begin
            r_state   <= R_AR;
            r_id      <= data_rd_acc;
            ar_addr_q <= data_rd_acc ? data_sram_addr : inst_sram_addr;
            ar_size_q <= data_rd_acc ? data_sram_size : inst_sram_size;
          end
        end
        R_AR: begin
          if (arready) r_state <= R_R;
        end
        R_R: begin
          if (rvalid) begin
            r_state <= R_RESP;
            rdata_q <= rdata;
            rsp_id  <= rid[0];
          end
        end
        R_RESP: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state   <= W_IDLE;
      aw_addr_q <= 32'd0;
      aw_size_q <= 2'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (data_wr_acc) begin
            w_state   <= W_AW_W;
            aw_addr_q <= data_sram_addr;
            aw_size_q <= data_sram_size;
            wdata_q   <= data_sram_wdata;
            wstrb_q   <= data_sram_wstrb;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
          end
        end
        W_AW_W: begin
          if (aw_fin && w_fin) begin
            w_state <= W_B;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        W_B: begin
          if (bvalid) w_state <= W_RESP;
        end
        W_RESP: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a wait-state AXI slave model.
// Table of single transactions plus ordering, stall and reset sequences.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // slave configuration and observations
  int ar_w, r_w, aw_w, w_w, b_w;
  logic [31:0] srdata;
  logic [3:0]  cap_arid, cap_awid, cap_wid;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [3:0]  cap_wstrb;
  logic        cap_wlast;
  logic [3:0]  arid_log[$];
  int b_cyc, ar_rise_cyc;

  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic r_pend, aw_got, w_got;
  logic [3:0] pend_id;

  // Slave drives on the falling edge; a ready/valid seen high here
  // means the handshake happened on the preceding rising edge.
  always @(negedge clk) begin
    if (!resetn) begin
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      r_pend = 0; aw_got = 0; w_got = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (arready) begin
        arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
      end else if (arvalid) begin
        if (ar_cnt < ar_w) ar_cnt++;
        else begin
          arready = 1;
          cap_arid = arid; cap_araddr = araddr; cap_arsize = arsize;
          arid_log.push_back(arid);
          pend_id = arid;
        end
      end
      if (rvalid) begin
        rvalid = 0; r_pend = 0;
      end else if (r_pend) begin
        if (r_cnt < r_w) r_cnt++;
        else begin
          rvalid = 1; rid = pend_id; rdata = srdata;
        end
      end
      if (bvalid) begin
        bvalid = 0; aw_got = 0; w_got = 0; b_cnt = 0;
      end
      if (awready) begin
        awready = 0; aw_cnt = 0; aw_got = 1;
      end else if (awvalid) begin
        if (aw_cnt < aw_w) aw_cnt++;
        else begin
          awready = 1;
          cap_awaddr = awaddr; cap_awsize = awsize; cap_awid = awid;
        end
      end
      if (wready) begin
        wready = 0; w_cnt = 0; w_got = 1;
      end else if (wvalid) begin
        if (w_cnt < w_w) w_cnt++;
        else begin
          wready = 1;
          cap_wdata = wdata; cap_wstrb = wstrb;
          cap_wid = wid; cap_wlast = wlast;
        end
      end
      if (aw_got && w_got && !bvalid) begin
        if (b_cnt < b_w) b_cnt++;
        else begin
          bvalid = 1; b_cyc = cyc;
        end
      end
    end
  end

  // handshake hold / drop monitor
  logic p_ok, p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [3:0]  p_arid;
  initial p_ok = 0;
  always begin
    @(negedge clk);
    #1;
    if (resetn && p_ok) begin
      if (p_arv && !p_arr) begin
        chk("arvalid hold", 32'(arvalid), 32'd1);
        chk("araddr hold", araddr, p_araddr);
        chk("arid hold", 32'(arid), 32'(p_arid));
      end
      if (p_arv && p_arr) chk("arvalid drop", 32'(arvalid), 32'd0);
      if (p_awv && !p_awr) begin
        chk("awvalid hold", 32'(awvalid), 32'd1);
        chk("awaddr hold", awaddr, p_awaddr);
      end
      if (p_awv && p_awr) chk("awvalid drop", 32'(awvalid), 32'd0);
      if (p_wv && !p_wr) begin
        chk("wvalid hold", 32'(wvalid), 32'd1);
        chk("wdata hold", wdata, p_wdata);
      end
      if (p_wv && p_wr) chk("wvalid drop", 32'(wvalid), 32'd0);
      if (!p_arv && arvalid) ar_rise_cyc = cyc;
    end
    p_ok = resetn;
    p_arv = arvalid; p_arr = arready; p_araddr = araddr; p_arid = arid;
    p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
    p_wv = wvalid; p_wr = wready; p_wdata = wdata;
  end

  task automatic accept(input bit port_d, input logic wr,
                        input logic [31:0] addr, input logic [1:0] size,
                        input logic [3:0] strb, input logic [31:0] wd,
                        output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    if (port_d) begin
      data_sram_req = 1; data_sram_wr = wr; data_sram_addr = addr;
      data_sram_size = size; data_sram_wstrb = strb;
      data_sram_wdata = wd;
    end else begin
      inst_sram_req = 1; inst_sram_wr = 0; inst_sram_addr = addr;
      inst_sram_size = size; inst_sram_wstrb = 0; inst_sram_wdata = 0;
    end
    while (acc < 0 && n < 100) begin
      #1;
      if (port_d ? data_sram_addr_ok : inst_sram_addr_ok) acc = cyc;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL accept timeout: port %0d addr %h", port_d, addr);
    end else begin
      @(posedge clk);
      #1;
    end
    if (port_d) data_sram_req = 0;
    else inst_sram_req = 0;
  endtask

  task automatic wait_ok(input bit port_d, output int okc,
                         output logic [31:0] rd);
    int n;
    n = 0;
    okc = -1;
    rd = 32'hx;
    while (okc < 0 && n < 100) begin
      if (port_d ? data_sram_data_ok : inst_sram_data_ok) begin
        okc = cyc;
        rd = port_d ? data_sram_rdata : inst_sram_rdata;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    if (okc < 0) begin
      checks++; errors++;
      $display("FAIL data_ok timeout: port %0d", port_d);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] wd;
    int          arw, rw, aww, ww, bw;
    logic [31:0] srd;
    int          lat;
    logic [3:0]  e_arid;
    logic [2:0]  e_size;
    logic [31:0] e_rd;
  } vec_t;

  vec_t v[8];
  int acc, okc, da, dok, ia, iok, wa, wo, racc, rok;
  logic [31:0] rd, rd2;

  initial begin
    v[0] = '{0, 0, 32'h1c000000, 2'd2, 4'h0, 32'h0,
             0, 0, 0, 0, 0, 32'h02800c04, 3, 4'd0, 3'b010, 32'h02800c04};
    v[1] = '{1, 0, 32'h1c008010, 2'd2, 4'h0, 32'h0,
             2, 1, 0, 0, 0, 32'hdeadbeef, 6, 4'd1, 3'b010, 32'hdeadbeef};
    v[2] = '{1, 0, 32'h1c00800e, 2'd1, 4'h0, 32'h0,
             0, 3, 0, 0, 0, 32'h0000abcd, 6, 4'd1, 3'b001, 32'h0000abcd};
    v[3] = '{1, 1, 32'h1c010002, 2'd0, 4'b0100, 32'h00aa0000,
             0, 0, 0, 3, 0, 32'h0, 6, 4'd0, 3'b000, 32'h0};
    v[4] = '{1, 1, 32'h1c010004, 2'd2, 4'b1111, 32'h12345678,
             0, 0, 2, 0, 2, 32'h0, 7, 4'd0, 3'b010, 32'h0};
    v[5] = '{1, 1, 32'h1c010008, 2'd1, 4'b0011, 32'h0000beef,
             0, 0, 0, 0, 0, 32'h0, 3, 4'd0, 3'b001, 32'h0};
    v[6] = '{0, 0, 32'h1c000004, 2'd2, 4'h0, 32'h0,
             1, 0, 0, 0, 0, 32'h28000000, 4, 4'd0, 3'b010, 32'h28000000};
    v[7] = '{1, 0, 32'h1c000010, 2'd0, 4'h0, 32'h0,
             0, 0, 0, 0, 0, 32'h000000ff, 3, 4'd1, 3'b000, 32'h000000ff};

    resetn = 0;
    inst_sram_req = 1; inst_sram_wr = 0; inst_sram_size = 2;
    inst_sram_wstrb = 0; inst_sram_addr = 32'h1c000000;
    inst_sram_wdata = 0;
    data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2;
    data_sram_wstrb = 0; data_sram_addr = 32'h1c000100;
    data_sram_wdata = 0;
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 1; bid = 1; bresp = 0;
    ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0; srdata = 0;
    b_cyc = 0; ar_rise_cyc = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst arvalid", 32'(arvalid), 0);
    chk("rst awvalid", 32'(awvalid), 0);
    chk("rst wvalid", 32'(wvalid), 0);
    chk("rst rready", 32'(rready), 0);
    chk("rst bready", 32'(bready), 0);
    chk("rst inst addr_ok", 32'(inst_sram_addr_ok), 0);
    chk("rst data addr_ok", 32'(data_sram_addr_ok), 0);
    chk("rst inst data_ok", 32'(inst_sram_data_ok), 0);
    chk("rst data data_ok", 32'(data_sram_data_ok), 0);
    chk("rst rdata", inst_sram_rdata, 0);
    chk("rst araddr", araddr, 0);
    chk("rst awaddr", awaddr, 0);
    inst_sram_req = 0;
    data_sram_req = 0;
    @(negedge clk);
    resetn = 1;

    for (int i = 0; i < 8; i++) begin
      ar_w = v[i].arw; r_w = v[i].rw;
      aw_w = v[i].aww; w_w = v[i].ww; b_w = v[i].bw;
      srdata = v[i].srd;
      accept(v[i].is_d, v[i].wr, v[i].addr, v[i].size, v[i].strb,
             v[i].wd, acc);
      wait_ok(v[i].is_d, okc, rd);
      chk($sformatf("v%0d latency", i), 32'(okc - acc), 32'(v[i].lat));
      if (!v[i].wr) begin
        chk($sformatf("v%0d arid", i), 32'(cap_arid), 32'(v[i].e_arid));
        chk($sformatf("v%0d araddr", i), cap_araddr, v[i].addr);
        chk($sformatf("v%0d arsize", i), 32'(cap_arsize),
            32'(v[i].e_size));
        chk($sformatf("v%0d rdata", i), rd, v[i].e_rd);
      end else begin
        chk($sformatf("v%0d awaddr", i), cap_awaddr, v[i].addr);
        chk($sformatf("v%0d awsize", i), 32'(cap_awsize),
            32'(v[i].e_size));
        chk($sformatf("v%0d wdata", i), cap_wdata, v[i].wd);
        chk($sformatf("v%0d wstrb", i), 32'(cap_wstrb), 32'(v[i].strb));
        chk($sformatf("v%0d awid", i), 32'(cap_awid), 32'd1);
        chk($sformatf("v%0d wid", i), 32'(cap_wid), 32'd1);
        chk($sformatf("v%0d wlast", i), 32'(cap_wlast), 32'd1);
      end
    end

    // same-cycle inst and data reads: data goes first
    ar_w = 0; r_w = 0; srdata = 32'h0badf00d;
    arid_log.delete();
    fork
      begin
        accept(1, 0, 32'h1c000200, 2'd2, 4'h0, 32'h0, da);
        wait_ok(1, dok, rd);
      end
      begin
        accept(0, 0, 32'h1c000100, 2'd2, 4'h0, 32'h0, ia);
        wait_ok(0, iok, rd2);
      end
    join
    chk("dual first arid", 32'(arid_log[0]), 32'd1);
    chk("dual second arid", 32'(arid_log[1]), 32'd0);
    chk("dual data latency", 32'(dok - da), 32'd3);
    chk("dual inst accept delay", 32'(ia - da), 32'd4);
    chk("dual inst latency", 32'(iok - ia), 32'd3);
    chk("dual inst rdata", rd2, 32'h0badf00d);

    // store then load to the same address
    b_w = 2; srdata = 32'h55667788;
    accept(1, 1, 32'h1c010010, 2'd2, 4'hf, 32'h55667788, wa);
    fork
      wait_ok(1, wo, rd);
      accept(1, 0, 32'h1c010010, 2'd2, 4'h0, 32'h0, racc);
    join
    wait_ok(1, rok, rd);
    chk("raw store latency", 32'(wo - wa), 32'd5);
    chk("raw load accept", 32'(racc - wo), 32'd1);
    chk("raw ar after b", 32'(ar_rise_cyc > b_cyc), 32'd1);
    chk("raw load latency", 32'(rok - racc), 32'd3);
    chk("raw load rdata", rd, 32'h55667788);

    // inst read stalled on arready while a data write completes
    b_w = 0; ar_w = 5; srdata = 32'h03400000;
    fork
      begin
        accept(0, 0, 32'h1c000300, 2'd2, 4'h0, 32'h0, ia);
        wait_ok(0, iok, rd);
      end
      begin
        accept(1, 1, 32'h1c010020, 2'd2, 4'hf, 32'ha5a5a5a5, wa);
        wait_ok(1, wo, rd2);
      end
    join
    chk("stall same-cycle accept", 32'(ia), 32'(wa));
    chk("stall write latency", 32'(wo - wa), 32'd3);
    chk("stall inst latency", 32'(iok - ia), 32'd8);
    chk("stall awaddr", cap_awaddr, 32'h1c010020);
    chk("stall inst rdata", rd, 32'h03400000);

    // reset while waiting for the R beat
    ar_w = 0; r_w = 10; srdata = 32'h11111111;
    accept(0, 0, 32'h1c000040, 2'd2, 4'h0, 32'h0, acc);
    @(posedge clk);
    #1;
    chk("pre-reset rready", 32'(rready), 32'd1);
    #1;
    resetn = 0;
    #1;
    chk("mid-reset rready", 32'(rready), 32'd0);
    chk("mid-reset arvalid", 32'(arvalid), 32'd0);
    chk("mid-reset rdata", data_sram_rdata, 32'd0);
    repeat (3) @(negedge clk);
    r_w = 0; srdata = 32'hcafef00d;
    resetn = 1;
    accept(0, 0, 32'h1c000080, 2'd2, 4'h0, 32'h0, acc);
    wait_ok(0, okc, rd);
    chk("post-reset latency", 32'(okc - acc), 32'd3);
    chk("post-reset araddr", cap_araddr, 32'h1c000080);
    chk("post-reset rdata", rd, 32'hcafef00d);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
